pipe_ctrl_unit: RTL and testbench

Pipelined control unit for the 5-stage MIPS core. It decodes the ID-stage opcode into a control word and carries that word through ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards and resolves branch and jump redirects, generating stall, flush and PC-select signals. It replaces the purely combinational opcode decoder and sits between the IF/ID register and the datapath stage registers.

---
 rtl/mips_ctrl_pkg.sv | 54 +++++
 rtl/pipe_ctrl_unit_decoder.sv | 63 ++++++
 rtl/pipe_ctrl_unit.sv | 136 +++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared control-path definitions for the MIPS pipeline control unit:
// opcodes, ALU op codes, operand-source and PC-source encodings, and the
// packed control word carried through the stage registers.
package mips_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int ALUOP_W    = 3;
  localparam int OPCODE_W   = 6;

  localparam logic [OPCODE_W-1:0] OP_R    = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J    = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BNE  = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_SUBI = 6'h09;
  localparam logic [OPCODE_W-1:0] OP_SLTI = 6'h0A;
  localparam logic [OPCODE_W-1:0] OP_ANDI = 6'h0C;
  localparam logic [OPCODE_W-1:0] OP_ORI  = 6'h0D;
  localparam logic [OPCODE_W-1:0] OP_XORI = 6'h0E;
  localparam logic [OPCODE_W-1:0] OP_LW   = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW   = 6'h2B;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALUOP_W-1:0] ALU_AND = 3'd2;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 3'd3;
  localparam logic [ALUOP_W-1:0] ALU_XOR = 3'd4;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 3'd5;
  localparam logic [ALUOP_W-1:0] ALU_R   = 3'd7;

  localparam logic [1:0] SRC_REG  = 2'd0;
  localparam logic [1:0] SRC_SEXT = 2'd1;
  localparam logic [1:0] SRC_ZEXT = 2'd2;

  localparam logic [1:0] PC_SEL_SEQ = 2'd0;
  localparam logic [1:0] PC_SEL_BR  = 2'd1;
  localparam logic [1:0] PC_SEL_JMP = 2'd2;

  typedef struct packed {
    logic               reg_dst;
    logic               j;
    logic               beq;
    logic               bne;
    logic               mem_read;
    logic               mem_to_reg;
    logic               mem_write;
    logic               reg_write;
    logic [1:0]         alu_src;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_unit_decoder.sv
// Combinational ID-stage opcode decode into a control word, plus the
// rs/rt usage flags consumed by the load-use hazard check.
// CTRL_ILLEGAL_TRAP_EN adds an illegal-opcode indication output.
module ctrl_decoder
  import mips_ctrl_pkg::*;
(
  input  logic                id_valid_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  output ctrl_word_t          word_o,
  output logic                rs_used_o,
  output logic                rt_used_o
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                illegal_o
`endif
);

  logic known;

  // Opcode table; unknown opcodes and empty slots decode to a bubble.
  always_comb begin
    word_o    = CTRL_BUBBLE;
    rs_used_o = 1'b0;
    rt_used_o = 1'b0;
    known     = 1'b1;
    if (id_valid_i) begin
      rs_used_o = 1'b1;
      case (opcode_i)
        OP_R:    begin word_o.reg_dst = 1'b1; word_o.reg_write = 1'b1;
                       word_o.alu_op = ALU_R; rt_used_o = 1'b1; end
        OP_J:    begin word_o.j = 1'b1; rs_used_o = 1'b0; end
        OP_BEQ:  begin word_o.beq = 1'b1; word_o.alu_op = ALU_SUB; rt_used_o = 1'b1; end
        OP_BNE:  begin word_o.bne = 1'b1; word_o.alu_op = ALU_SUB; rt_used_o = 1'b1; end
        OP_ADDI: begin word_o.reg_write = 1'b1; word_o.alu_src = SRC_SEXT;
                       word_o.alu_op = ALU_ADD; end
        OP_SUBI: begin word_o.reg_write = 1'b1; word_o.alu_src = SRC_SEXT;
                       word_o.alu_op = ALU_SUB; end
        OP_SLTI: begin word_o.reg_write = 1'b1; word_o.alu_src = SRC_SEXT;
                       word_o.alu_op = ALU_SLT; end
        OP_ANDI: begin word_o.reg_write = 1'b1; word_o.alu_src = SRC_ZEXT;
                       word_o.alu_op = ALU_AND; end
        OP_ORI:  begin word_o.reg_write = 1'b1; word_o.alu_src = SRC_ZEXT;
                       word_o.alu_op = ALU_OR; end
        OP_XORI: begin word_o.reg_write = 1'b1; word_o.alu_src = SRC_ZEXT;
                       word_o.alu_op = ALU_XOR; end
        OP_LW:   begin word_o.mem_read = 1'b1; word_o.mem_to_reg = 1'b1;
                       word_o.reg_write = 1'b1; word_o.alu_src = SRC_SEXT;
                       word_o.alu_op = ALU_ADD; end
        OP_SW:   begin word_o.mem_write = 1'b1; word_o.alu_src = SRC_SEXT;
                       word_o.alu_op = ALU_ADD; rt_used_o = 1'b1; end
        default: begin known = 1'b0; rs_used_o = 1'b0; end
      endcase
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal_o = id_valid_i & ~known;
`else
  logic unused_known;
  assign unused_known = known;
`endif

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes ID, carries control through ID/EX,
// EX/MEM and MEM/WB, and resolves load-use stalls and branch/jump
// redirects with priority branch > load-use > jump.
// CTRL_ILLEGAL_TRAP_EN adds the sticky illegal_op output.
module pipe_ctrl_unit
  import mips_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [OPCODE_W-1:0]   id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  ex_zero,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  ifid_flush,
  output logic [1:0]            pc_sel,
  output logic                  ex_reg_dst,
  output logic [1:0]            ex_alu_src,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic                  ex_beq,
  output logic                  ex_bne,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                  illegal_op
`endif
);

  ctrl_word_t            id_word;
  ctrl_word_t            id_ex_q, id_ex_d;
  logic [REG_ADDR_W-1:0] id_ex_rt_q, id_ex_rt_d;
  logic                  rs_used, rt_used;
  logic                  ex_mem_rd_q, ex_mem_wr_q, ex_mem_rw_q, ex_mem_m2r_q;
  logic                  mem_wb_rw_q, mem_wb_m2r_q;
  logic                  bt, hz, jp;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic id_illegal;
  logic illegal_q;
`endif

  ctrl_decoder u_dec (
    .id_valid_i (id_valid),
    .opcode_i   (id_opcode),
    .word_o     (id_word),
    .rs_used_o  (rs_used),
    .rt_used_o  (rt_used)
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal_o  (id_illegal)
`endif
  );

  // Redirect/hazard events are suppressed while reset is held so the
  // control outputs read as idle during reset.
  assign bt = ~reset & ((id_ex_q.beq & ex_zero) | (id_ex_q.bne & ~ex_zero));
  assign hz = ~reset & id_ex_q.mem_read & (id_ex_rt_q != '0) &
              (((id_ex_rt_q == id_rs) & rs_used) | ((id_ex_rt_q == id_rt) & rt_used));
  assign jp = ~reset & id_word.j;

  // Front-end control and ID/EX next value under bt > hz > jp priority.
  always_comb begin
    pc_sel     = PC_SEL_SEQ;
    pc_stall   = 1'b0;
    ifid_flush = 1'b0;
    id_ex_d    = id_word;
    id_ex_rt_d = id_rt;
    if (bt) begin
      pc_sel     = PC_SEL_BR;
      ifid_flush = 1'b1;
      id_ex_d    = CTRL_BUBBLE;
      id_ex_rt_d = '0;
    end else if (hz) begin
      pc_stall   = 1'b1;
      id_ex_d    = CTRL_BUBBLE;
      id_ex_rt_d = '0;
    end else if (jp) begin
      pc_sel     = PC_SEL_JMP;
      ifid_flush = 1'b1;
    end
  end

  assign ifid_stall = pc_stall;

  // Stage registers; EX/MEM and MEM/WB advance every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_ex_q      <= CTRL_BUBBLE;
      id_ex_rt_q   <= '0;
      ex_mem_rd_q  <= 1'b0;
      ex_mem_wr_q  <= 1'b0;
      ex_mem_rw_q  <= 1'b0;
      ex_mem_m2r_q <= 1'b0;
      mem_wb_rw_q  <= 1'b0;
      mem_wb_m2r_q <= 1'b0;
    end else begin
      id_ex_q      <= id_ex_d;
      id_ex_rt_q   <= id_ex_rt_d;
      ex_mem_rd_q  <= id_ex_q.mem_read;
      ex_mem_wr_q  <= id_ex_q.mem_write;
      ex_mem_rw_q  <= id_ex_q.reg_write;
      ex_mem_m2r_q <= id_ex_q.mem_to_reg;
      mem_wb_rw_q  <= ex_mem_rw_q;
      mem_wb_m2r_q <= ex_mem_m2r_q;
    end
  end

  logic unused_j;
  assign unused_j = id_ex_q.j;

  assign ex_reg_dst    = id_ex_q.reg_dst;
  assign ex_alu_src    = id_ex_q.alu_src;
  assign ex_alu_op     = id_ex_q.alu_op;
  assign ex_beq        = id_ex_q.beq;
  assign ex_bne        = id_ex_q.bne;
  assign mem_read      = ex_mem_rd_q;
  assign mem_write     = ex_mem_wr_q;
  assign wb_reg_write  = mem_wb_rw_q;
  assign wb_mem_to_reg = mem_wb_m2r_q;

`ifdef CTRL_ILLEGAL_TRAP_EN
  // Sticky illegal flag; an illegal op squashed by a taken branch is ignored.
  always_ff @(posedge clk) begin
    if (reset)                  illegal_q <= 1'b0;
    else if (id_illegal & ~bt)  illegal_q <= 1'b1;
  end

  assign illegal_op = illegal_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed test-plan sequences
// followed by randomized stimulus, all compared against a slot-level
// pipeline model. Honors CTRL_ILLEGAL_TRAP_EN.
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt;
  logic       ex_zero;
  logic       pc_stall, ifid_stall, ifid_flush;
  logic [1:0] pc_sel;
  logic       ex_reg_dst;
  logic [1:0] ex_alu_src;
  logic [2:0] ex_alu_op;
  logic       ex_beq, ex_bne, mem_read, mem_write, wb_reg_write, wb_mem_to_reg;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  always #5 clk = ~clk;

  pipe_ctrl_unit dut (
    .clk           (clk),
    .reset         (reset),
    .id_valid      (id_valid),
    .id_opcode     (id_opcode),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .ex_zero       (ex_zero),
    .pc_stall      (pc_stall),
    .ifid_stall    (ifid_stall),
    .ifid_flush    (ifid_flush),
    .pc_sel        (pc_sel),
    .ex_reg_dst    (ex_reg_dst),
    .ex_alu_src    (ex_alu_src),
    .ex_alu_op     (ex_alu_op),
    .ex_beq        (ex_beq),
    .ex_bne        (ex_bne),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_to_reg (wb_mem_to_reg)
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal_op    (illegal_op)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Model: each pipeline slot holds the instruction that occupies it.
  typedef struct {
    bit       v;
    bit [5:0] op;
    bit [4:0] rt;
  } slot_t;

  typedef struct {
    bit       known, rd, j, beq, bne, mr, mw, rw, m2r;
    bit [1:0] src;
    bit [2:0] alu;
  } fld_t;

  localparam slot_t EMPTY = '{v: 1'b0, op: 6'h0, rt: 5'h0};

  slot_t m_idex = EMPTY, m_exmem = EMPTY, m_memwb = EMPTY;
  bit    m_ill = 1'b0;

  bit [5:0] legal_ops [12] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09,
                               6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B};

  function automatic fld_t dec(input bit v, input bit [5:0] op);
    fld_t f = '{default: 0};
    if (!v) return f;
    f.known = 1'b1;
    case (op)
      6'h00: begin f.rd = 1; f.rw = 1; f.alu = 7; end
      6'h02: f.j = 1;
      6'h04: begin f.beq = 1; f.alu = 1; end
      6'h05: begin f.bne = 1; f.alu = 1; end
      6'h08: begin f.rw = 1; f.src = 1; f.alu = 0; end
      6'h09: begin f.rw = 1; f.src = 1; f.alu = 1; end
      6'h0A: begin f.rw = 1; f.src = 1; f.alu = 5; end
      6'h0C: begin f.rw = 1; f.src = 2; f.alu = 2; end
      6'h0D: begin f.rw = 1; f.src = 2; f.alu = 3; end
      6'h0E: begin f.rw = 1; f.src = 2; f.alu = 4; end
      6'h23: begin f.mr = 1; f.m2r = 1; f.rw = 1; f.src = 1; f.alu = 0; end
      6'h2B: begin f.mw = 1; f.src = 1; f.alu = 0; end
      default: f.known = 1'b0;
    endcase
    return f;
  endfunction

  // One cycle: drive ID at the falling edge, check, then advance the model.
  task automatic step(input bit rst, input bit v, input bit [5:0] op,
                      input bit [4:0] rs, input bit [4:0] rt, input bit z);
    fld_t  fi, fe, fm, fw;
    bit    bt, hz, jp, rs_u, rt_u;
    bit [1:0] sel;
    @(negedge clk);
    reset = rst; id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; ex_zero = z;
    #1;
    fi = dec(v, op);
    fe = dec(m_idex.v, m_idex.op);
    fm = dec(m_exmem.v, m_exmem.op);
    fw = dec(m_memwb.v, m_memwb.op);
    rs_u = fi.known && op != 6'h02;
    rt_u = v && (op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2B);
    bt = !rst && ((fe.beq && z) || (fe.bne && !z));
    hz = !rst && fe.mr && m_idex.rt != 0 &&
         ((m_idex.rt == rs && rs_u) || (m_idex.rt == rt && rt_u));
    jp = !rst && fi.j;
    sel = bt ? 2'd1 : (hz ? 2'd0 : (jp ? 2'd2 : 2'd0));
    check_eq("pc_stall",   pc_stall,   hz && !bt);
    check_eq("ifid_stall", ifid_stall, hz && !bt);
    check_eq("ifid_flush", ifid_flush, bt || (jp && !hz));
    check_eq("pc_sel",     pc_sel,     sel);
    check_eq("ex_reg_dst", ex_reg_dst, fe.rd);
    check_eq("ex_alu_src", ex_alu_src, fe.src);
    check_eq("ex_alu_op",  ex_alu_op,  fe.alu);
    check_eq("ex_beq",     ex_beq,     fe.beq);
    check_eq("ex_bne",     ex_bne,     fe.bne);
    check_eq("mem_read",   mem_read,   fm.mr);
    check_eq("mem_write",  mem_write,  fm.mw);
    check_eq("wb_reg_write",  wb_reg_write,  fw.rw);
    check_eq("wb_mem_to_reg", wb_mem_to_reg, fw.m2r);
`ifdef CTRL_ILLEGAL_TRAP_EN
    check_eq("illegal_op", illegal_op, m_ill);
`endif
    @(posedge clk);
    if (rst) begin
      m_idex = EMPTY; m_exmem = EMPTY; m_memwb = EMPTY; m_ill = 1'b0;
    end else begin
      if (v && !fi.known && !bt) m_ill = 1'b1;
      m_memwb = m_exmem;
      m_exmem = m_idex;
      m_idex  = (bt || hz) ? EMPTY : '{v: v, op: op, rt: rt};
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 6'h00, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    bit [5:0] rop;
    reset = 1'b1; id_valid = 1'b0; id_opcode = '0; id_rs = '0; id_rt = '0; ex_zero = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    step(1'b1, 1'b0, 6'h00, 5'd0, 5'd0, 1'b0);
    idle(1);

    // Decode sweep; ex_zero chosen so no branch in EX is taken
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, legal_ops[i], 5'd1, 5'd2, (i > 0 && legal_ops[i-1] == 6'h05));
      if (legal_ops[i] == 6'h0D) begin
        #1;
        check_eq("ori_alu_src", ex_alu_src, 32'd2);
        check_eq("ori_alu_op",  ex_alu_op,  32'd3);
      end
    end
    idle(4);

    // Load-use: lw rt=8, then R with rs=8 stalls once and is re-issued
    step(1'b0, 1'b1, 6'h23, 5'd1, 5'd8, 1'b0);
    step(1'b0, 1'b1, 6'h00, 5'd8, 5'd3, 1'b0);
    #1 check_eq("lu_bubble", {ex_reg_dst, ex_alu_src, ex_alu_op, ex_beq, ex_bne}, 32'd0);
    step(1'b0, 1'b1, 6'h00, 5'd8, 5'd3, 1'b0);
    #1 check_eq("lu_reissue", ex_reg_dst, 32'd1);
    idle(3);

    // Load-use against r0 never stalls
    step(1'b0, 1'b1, 6'h23, 5'd1, 5'd0, 1'b0);
    step(1'b0, 1'b1, 6'h00, 5'd0, 5'd0, 1'b0);
    #1 check_eq("lu_r0_adv", ex_reg_dst, 32'd1);
    idle(3);

    // Branches: beq/bne taken and not taken
    step(1'b0, 1'b1, 6'h04, 5'd1, 5'd2, 1'b0);
    step(1'b0, 1'b1, 6'h08, 5'd3, 5'd4, 1'b1);
    #1 check_eq("beq_taken_bubble", ex_alu_src, 32'd0);
    step(1'b0, 1'b1, 6'h04, 5'd1, 5'd2, 1'b0);
    step(1'b0, 1'b1, 6'h08, 5'd3, 5'd4, 1'b0);
    #1 check_eq("beq_nt_adv", ex_alu_src, 32'd1);
    step(1'b0, 1'b1, 6'h05, 5'd1, 5'd2, 1'b0);
    step(1'b0, 1'b1, 6'h08, 5'd3, 5'd4, 1'b1);
    #1 check_eq("bne_nt_adv", ex_alu_src, 32'd1);
    step(1'b0, 1'b1, 6'h05, 5'd1, 5'd2, 1'b0);
    step(1'b0, 1'b1, 6'h08, 5'd3, 5'd4, 1'b0);
    #1 check_eq("bne_taken_bubble", ex_alu_src, 32'd0);
    idle(3);

    // Reset asserted in the cycle that would stall
    step(1'b0, 1'b1, 6'h23, 5'd1, 5'd8, 1'b0);
    step(1'b1, 1'b1, 6'h00, 5'd8, 5'd3, 1'b0);
    #1 check_eq("rst_stages", {ex_reg_dst, ex_alu_src, ex_alu_op, ex_beq, ex_bne,
                               mem_read, mem_write, wb_reg_write, wb_mem_to_reg}, 32'd0);
    step(1'b0, 1'b1, 6'h00, 5'd8, 5'd3, 1'b0);
    idle(3);

    // Illegal opcode becomes a bubble (and sets the sticky flag when enabled)
    step(1'b0, 1'b1, 6'h3F, 5'd1, 5'd2, 1'b0);
    #1 check_eq("ill_bubble", {ex_reg_dst, ex_alu_src, ex_alu_op, ex_beq, ex_bne}, 32'd0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    check_eq("ill_flag", illegal_op, 32'd1);
`endif
    idle(4);
    step(1'b1, 1'b0, 6'h00, 5'd0, 5'd0, 1'b0);
    idle(1);

    // Randomized traffic with small register range to provoke hazards
    for (int n = 0; n < 500; n++) begin
      rop = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63))
                                        : legal_ops[$urandom_range(0, 11)];
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0), rop,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
